// File: rtl/train_sequencer.sv
// Training/inference sequencer for a single associate neuron: replays a small
// sample store, returns saturated errors, and reports per-epoch absolute loss.
module train_sequencer #(
  parameter int N      = 2,
  parameter int DEPTH  = 4,
  parameter int EPOCHS = 16
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       ld_valid,
  input  logic [$clog2(DEPTH)-1:0]   ld_addr,
  input  logic [N*8-1:0]             ld_arg,
  input  logic [15:0]                ld_target,
  output logic                       ld_ready,
  input  logic                       start,
  input  logic                       mode,
  input  logic [$clog2(DEPTH):0]     count,
  output logic                       busy,
  output logic                       done,
  output logic                       loss_valid,
  output logic [23:0]                loss_data,
  output logic                       train,
  output logic                       arg_valid,
  output logic [N*8-1:0]             arg_data,
  input  logic                       arg_ready,
  input  logic                       res_valid,
  input  logic [15:0]                res_data,
  output logic                       res_ready,
  output logic                       err_valid,
  output logic [15:0]                err_data,
  input  logic                       err_ready,
  input  logic                       fbk_valid,
  input  logic [N*16-1:0]            fbk_data,
  output logic                       fbk_ready
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = $clog2(EPOCHS) + 1;
  localparam int SW = N * 8 + 16;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_ARG, S_RES, S_ERR, S_FBK, S_NEXT, S_DONE
  } state_t;

  state_t          state_r, state_next;
  logic [AW-1:0]   idx_r, idx_next, last_r, last_next;
  logic [EW-1:0]   epoch_r, epoch_next;
  logic            mode_r, mode_next;
  logic [23:0]     acc_r, acc_next;
  logic [N*8-1:0]  arg_r, arg_next;
  logic [15:0]     tgt_r, tgt_next, err_r, err_next, e_s;
  logic [SW-1:0]   mem_r [DEPTH];
  logic            ld_ready_r, busy_r, done_r, loss_valid_r, train_r;
  logic            arg_valid_r, res_ready_r, err_valid_r, fbk_ready_r;
  logic            busy_next;
  logic            unused_fbk_s;

  // 17-bit signed difference clipped back into the 16-bit signed range
  function automatic logic [15:0] sat_err(input logic [15:0] tgt, input logic [15:0] res);
    logic [16:0] d;
    d = {tgt[15], tgt} - {res[15], res};
    if (d[16:15] == 2'b01) begin
      return 16'h7FFF;
    end else if (d[16:15] == 2'b10) begin
      return 16'h8000;
    end else begin
      return d[15:0];
    end
  endfunction

  function automatic logic [16:0] abs_err(input logic [15:0] e);
    if (e[15]) begin
      return {1'b0, ~e} + 17'd1;
    end else begin
      return {1'b0, e};
    end
  endfunction

  function automatic logic [23:0] sat_add(input logic [23:0] acc, input logic [16:0] a);
    logic [24:0] s;
    s = {1'b0, acc} + {8'd0, a};
    if (s[24]) begin
      return 24'hFFFFFF;
    end else begin
      return s[23:0];
    end
  endfunction

  function automatic logic [AW-1:0] last_of(input logic [CW-1:0] c);
    if (c == {CW{1'b0}}) begin
      return {AW{1'b0}};
    end else if (c > CW'(DEPTH)) begin
      return AW'(DEPTH - 1);
    end else begin
      return AW'(c - CW'(1));
    end
  endfunction

  assign unused_fbk_s = ^fbk_data;
  assign e_s          = sat_err(tgt_r, res_data);

  // Sample store write port; deliberately unreset so contents survive reset
  always_ff @(posedge clock) begin
    if (ld_valid && ld_ready_r) begin
      mem_r[ld_addr] <= {ld_arg, ld_target};
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_next = state_r;
    idx_next   = idx_r;
    last_next  = last_r;
    epoch_next = epoch_r;
    mode_next  = mode_r;
    acc_next   = acc_r;
    arg_next   = arg_r;
    tgt_next   = tgt_r;
    err_next   = err_r;
    case (state_r)
      S_IDLE: begin
        if (start) begin
          mode_next  = mode;
          last_next  = last_of(count);
          idx_next   = {AW{1'b0}};
          epoch_next = {EW{1'b0}};
          acc_next   = 24'd0;
          state_next = S_FETCH;
        end else begin
          state_next = S_IDLE;
        end
      end
      S_FETCH: begin
        {arg_next, tgt_next} = mem_r[idx_r];
        state_next           = S_ARG;
      end
      S_ARG: begin
        if (arg_ready) begin
          state_next = S_RES;
        end else begin
          state_next = S_ARG;
        end
      end
      S_RES: begin
        if (res_valid) begin
          err_next   = e_s;
          acc_next   = sat_add(acc_r, abs_err(e_s));
          state_next = mode_r ? S_ERR : S_NEXT;
        end else begin
          state_next = S_RES;
        end
      end
      S_ERR: begin
        if (err_ready) begin
          state_next = S_FBK;
        end else begin
          state_next = S_ERR;
        end
      end
      S_FBK: begin
        if (fbk_valid) begin
          state_next = S_NEXT;
        end else begin
          state_next = S_FBK;
        end
      end
      S_NEXT: begin
        if (idx_r != last_r) begin
          idx_next   = idx_r + AW'(1);
          state_next = S_FETCH;
        end else begin
          idx_next = {AW{1'b0}};
          // A perfect epoch stops training early
          if (!mode_r || (epoch_r == EW'(EPOCHS - 1)) || (acc_r == 24'd0)) begin
            state_next = S_DONE;
          end else begin
            epoch_next = epoch_r + EW'(1);
            acc_next   = 24'd0;
            state_next = S_FETCH;
          end
        end
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  assign busy_next = (state_next inside {S_FETCH, S_ARG, S_RES, S_ERR, S_FBK, S_NEXT});

  // State, datapath and output registers; handshake outputs decode the next state
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r      <= S_IDLE;
      idx_r        <= {AW{1'b0}};
      last_r       <= {AW{1'b0}};
      epoch_r      <= {EW{1'b0}};
      mode_r       <= 1'b0;
      acc_r        <= 24'd0;
      arg_r        <= {(N*8){1'b0}};
      tgt_r        <= 16'd0;
      err_r        <= 16'd0;
      ld_ready_r   <= 1'b1;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      loss_valid_r <= 1'b0;
      train_r      <= 1'b0;
      arg_valid_r  <= 1'b0;
      res_ready_r  <= 1'b0;
      err_valid_r  <= 1'b0;
      fbk_ready_r  <= 1'b0;
    end else begin
      state_r      <= state_next;
      idx_r        <= idx_next;
      last_r       <= last_next;
      epoch_r      <= epoch_next;
      mode_r       <= mode_next;
      acc_r        <= acc_next;
      arg_r        <= arg_next;
      tgt_r        <= tgt_next;
      err_r        <= err_next;
      ld_ready_r   <= (state_next == S_IDLE);
      busy_r       <= busy_next;
      done_r       <= (state_next == S_DONE);
      loss_valid_r <= (state_next == S_NEXT) && (idx_next == last_next);
      train_r      <= busy_next ? mode_next : 1'b0;
      arg_valid_r  <= (state_next == S_ARG);
      res_ready_r  <= (state_next == S_RES);
      err_valid_r  <= (state_next == S_ERR);
      fbk_ready_r  <= (state_next == S_FBK);
    end
  end

  assign ld_ready   = ld_ready_r;
  assign busy       = busy_r;
  assign done       = done_r;
  assign loss_valid = loss_valid_r;
  assign loss_data  = acc_r;
  assign train      = train_r;
  assign arg_valid  = arg_valid_r;
  assign arg_data   = arg_r;
  assign res_ready  = res_ready_r;
  assign err_valid  = err_valid_r;
  assign err_data   = err_r;
  assign fbk_ready  = fbk_ready_r;

endmodule

// File: doc/train_sequencer.md
# train_sequencer

Sequencer that owns one `associate` neuron and drives complete training and inference runs over a small on-chip sample store. It presents each stored argument vector, collects the inner-product result, and computes and returns the saturated error `target - result`. It accepts and discards the neuron's feedback, repeats for a programmed number of epochs, and reports per-epoch absolute-error loss. It sits between the host/config bus and a single `associate` instance, replacing ad-hoc testbench sequencing.

## Interface
- `N`, 2: argument vector length; must match the attached `associate`.
- `DEPTH`, 4: number of sample slots; a power of two, at least 2.
- `EPOCHS`, 16: maximum training epochs per run.
- Ports: clock and reset first, then the load, run-control, loss and neuron sides.
- `clock` in 1: clock.
- `reset` in 1: reset, synchronous, active-high.
- `ld_valid` in 1: sample write request.
- `ld_addr` in clog2(DEPTH): slot index.
- `ld_arg` in N×8: argument vector to store.
- `ld_target` in 16: signed target to store.
- `ld_ready` out 1: high only in IDLE.
- `start` in 1: begin a run; sampled in IDLE only.
- `mode` in 1: captured at start; 1 = train, 0 = single inference pass.
- `count` in clog2(DEPTH)+1: number of active samples (1..DEPTH), captured at start.
- `busy` out 1: high from the cycle after start accept until `done`.
- `done` out 1: one-cycle pulse at run end.
- `loss_valid` out 1: one-cycle pulse at the end of each epoch.
- `loss_data` out 24: that epoch's Σ|error|, saturating at 24'hFFFFFF.
- `train` out 1: held at captured `mode` while busy, 0 otherwise.
- `arg_valid` out 1, `arg_data` out N×8, `arg_ready` in 1: argument channel to the neuron.
- `res_valid` in 1, `res_data` in 16, `res_ready` out 1: result channel from the neuron.
- `err_valid` out 1, `err_data` out 16, `err_ready` in 1: error channel to the neuron.
- `fbk_valid` in 1, `fbk_data` in N×16, `fbk_ready` out 1: feedback from the neuron; data is ignored.

## Operation
- Sample store: DEPTH slots × (N·8+16) bits, written on `ld_valid & ld_ready`. The store has no reset; contents survive `reset`.
- States: IDLE, FETCH, ARG, RES, ERR, FBK, NEXT, DONE.
- IDLE: `start` captures `mode` and `count`, clears the sample index, epoch counter and loss accumulator, then goes to FETCH. A `count` of 0 is treated as 1, and values greater than DEPTH are clamped to DEPTH.
- FETCH: registered read of the slot at the sample index; go to ARG.
- ARG: `arg_valid` = 1 with the fetched vector. On `arg_valid & arg_ready` go to RES.
- RES: `res_ready` = 1. On `res_valid`, compute e = sat16(target − res) in 17-bit signed arithmetic: +32767 for e > 32767, −32768 for e < −32768. Add |e| to the loss accumulator; |−32768| = 32768. Go to ERR if train, otherwise NEXT.
- ERR: `err_valid` = 1 with `err_data` = e. On handshake go to FBK.
- FBK: `fbk_ready` = 1. On `fbk_valid` go to NEXT.
- NEXT:
  - If the index is not the last sample, increment it and go to FETCH.
  - Otherwise pulse `loss_valid` with the accumulator value and wrap the index to 0.
  - Inference mode: go to DONE.
  - Train mode: go to DONE if epoch+1 == EPOCHS or the epoch loss is 0. Otherwise increment the epoch, clear the accumulator and go to FETCH.
- DONE: pulse `done`, deassert `busy`, return to IDLE.
- Only one valid/ready pair toward the neuron is active in any state. Outputs hold stable while valid and not yet accepted.
- `start` outside IDLE is ignored.

## Timing
- Reset values of all outputs are 0: `busy`, `done`, `loss_valid`, `loss_data`, `train`, `arg_valid`, `arg_data`, `res_ready`, `err_valid`, `err_data`, `fbk_ready`. `ld_ready` is 1 after reset because state resets to IDLE.
- `reset` mid-run:
  - Next state is IDLE, and counters and accumulator clear.
  - The neuron must be reset in the same cycle by the integrator; the sequencer does not resynchronise with a neuron left mid-transaction.
- Pipeline timing:
  - Start accept at cycle t → FETCH at t+1 → `arg_valid` high at t+2.
  - Each handshake advances state the following cycle.
  - NEXT costs one cycle; `loss_valid` is asserted during NEXT of the last sample.
- The loss accumulator saturates and never wraps.

## Test plan
- Load slot 0 = {arg (8'h40, 8'h40), target 16'h0100}, `count`=1, `mode`=0, stub neuron returns 16'h0040 → `err_valid` never asserted; `loss_valid` pulses with 24'h0000C0; `done` pulses once; `busy` drops in the same cycle.
- Same setup with `mode`=1, stub neuron returning 16'h0040 every time → per sample, `err_data`=16'h00C0 and `fbk_ready` is accepted; `loss_valid` pulses 16 times, then `done`.
- `mode`=1, stub returns the target exactly on the first sample → one `loss_valid` with 0, then `done` (early stop after epoch 1).
- Saturation: target 16'h7FFF, result 16'h8000 → `err_data`=16'h7FFF and loss adds 32767; target 16'h8000, result 16'h7FFF → `err_data`=16'h8000 and loss adds 32768.
- Backpressure: hold `arg_ready`, `err_ready` and `fbk_valid` low for 5 cycles each → valids and data stay stable, and there is no state advance or duplicate loss accumulation.
- Assert `reset` during ERR of sample 2 in epoch 3 → next cycle IDLE, all outputs 0; a new `start` replays from slot 0, epoch 0, with the stored samples intact.
- Integration: two DEPTH=4 AND-gate samples through a real `associate` with N=2 → epoch loss is non-increasing over 16 epochs.
